// File: rtl/fast_pkg.sv
// Shared types and sizing for the FAST mask builder slice.
// Optional score path is enabled with FAST_SCORE_EN.
package fast_pkg;

    localparam int CIRCLE_N = 16;
    localparam int MASK_W   = 16;

    typedef logic [MASK_W-1:0] fast_mask_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } fast_bld_state_t;

    function automatic int score_w(input int pixel_w);
        return pixel_w + 4;
    endfunction

endpackage

// File: rtl/fast_pixel_cmp.sv
// Thresholds one circle pixel against centre c with threshold t (diff output only with FAST_SCORE_EN).
// Latency: purely combinational.
// Backpressure: none; no state.
module fast_pixel_cmp #(
    parameter int PIXEL_W = 8
) (
    input  logic [PIXEL_W-1:0] c,
    input  logic [PIXEL_W-1:0] t,
    input  logic [PIXEL_W-1:0] p,
    output logic               darker,
    output logic               brighter
`ifdef FAST_SCORE_EN
    ,
    output logic [PIXEL_W-1:0] diff
`endif
);

    // One extra bit so c+t never wraps and c-t underflow is caught by the c>=t guard.
    logic [PIXEL_W:0] c_x;
    logic [PIXEL_W:0] t_x;
    logic [PIXEL_W:0] p_x;
    logic [PIXEL_W:0] lo;
    logic [PIXEL_W:0] hi;

    assign c_x = {1'b0, c};
    assign t_x = {1'b0, t};
    assign p_x = {1'b0, p};
    assign lo  = c_x - t_x;
    assign hi  = c_x + t_x;

    assign darker   = (c_x >= t_x) && (p_x < lo);
    assign brighter = (p_x > hi);

`ifdef FAST_SCORE_EN
    // Both differences are below 2**PIXEL_W whenever their flag is set.
    always_comb begin
        diff = '0;
        if (brighter) begin
            diff = PIXEL_W'(p_x - hi);
        end else if (darker) begin
            diff = PIXEL_W'(lo - p_x);
        end
    end
`endif

endmodule

// File: rtl/fast_mask_builder.sv
// Builds 16-bit darker/brighter masks from a 17-beat pixel packet (centre, then circle 0..15); FAST_SCORE_EN adds score.
// Latency: out_valid rises the cycle after the 16th circle beat is accepted.
// Backpressure: in_ready drops while results are held; masks stay until out_ready, ce=0 freezes everything.
module fast_mask_builder
    import fast_pkg::*;
#(
    parameter int PIXEL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [PIXEL_W-1:0] thresh,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sop,
    input  logic [PIXEL_W-1:0] in_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        mask_d,
    output logic [15:0]        mask_b,
    output logic               sync_err
`ifdef FAST_SCORE_EN
    ,
    output logic [score_w(PIXEL_W)-1:0] score
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(CIRCLE_N - 1);

    fast_bld_state_t    state_q;
    fast_bld_state_t    state_d;
    logic [3:0]         count_q;
    logic [3:0]         bit_idx;
    logic [PIXEL_W-1:0] c_q;
    logic [PIXEL_W-1:0] t_q;
    fast_mask_t         mask_d_q;
    fast_mask_t         mask_b_q;
    logic               sync_err_q;

    logic accept;
    logic start;
    logic write;
    logic drop;
    logic px_darker;
    logic px_brighter;

`ifdef FAST_SCORE_EN
    localparam int SCORE_W = score_w(PIXEL_W);
    logic [PIXEL_W-1:0] px_diff;
    logic [SCORE_W-1:0] sum_b_q;
    logic [SCORE_W-1:0] sum_d_q;
    logic [SCORE_W-1:0] sum_b_nx;
    logic [SCORE_W-1:0] sum_d_nx;
    logic [SCORE_W-1:0] score_q;
`endif

    assign in_ready  = ce && !rst && (state_q != HOLD);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign mask_d    = mask_d_q;
    assign mask_b    = mask_b_q;
    assign sync_err  = sync_err_q;
    assign bit_idx   = LAST_IDX - count_q;

    fast_pixel_cmp #(
        .PIXEL_W (PIXEL_W)
    ) u_cmp (
        .c        (c_q),
        .t        (t_q),
        .p        (in_pixel),
        .darker   (px_darker),
        .brighter (px_brighter)
`ifdef FAST_SCORE_EN
        ,
        .diff     (px_diff)
`endif
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        write   = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_sop) begin
                        start   = 1'b1;
                        state_d = COLLECT;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    // A fresh sop mid-packet is a silent resync, not an error.
                    if (in_sop) begin
                        start = 1'b1;
                    end else begin
                        write = 1'b1;
                        if (count_q == LAST_IDX) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            c_q        <= '0;
            t_q        <= '0;
            mask_d_q   <= '0;
            mask_b_q   <= '0;
            sync_err_q <= 1'b0;
        end else if (ce) begin
            state_q    <= state_d;
            sync_err_q <= drop;
            if (start) begin
                c_q      <= in_pixel;
                t_q      <= thresh;
                mask_d_q <= '0;
                mask_b_q <= '0;
                count_q  <= '0;
            end else if (write) begin
                mask_d_q[bit_idx] <= px_darker;
                mask_b_q[bit_idx] <= px_brighter;
                count_q           <= count_q + 4'd1;
            end
        end
    end

`ifdef FAST_SCORE_EN
    always_comb begin
        sum_b_nx = sum_b_q + (px_brighter ? SCORE_W'(px_diff) : '0);
        sum_d_nx = sum_d_q + (px_darker   ? SCORE_W'(px_diff) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_b_q <= '0;
            sum_d_q <= '0;
            score_q <= '0;
        end else if (ce) begin
            if (start) begin
                sum_b_q <= '0;
                sum_d_q <= '0;
            end else if (write) begin
                sum_b_q <= sum_b_nx;
                sum_d_q <= sum_d_nx;
                if (count_q == LAST_IDX) begin
                    score_q <= (sum_b_nx > sum_d_nx) ? sum_b_nx : sum_d_nx;
                end
            end
        end
    end

    assign score = score_q;
`endif

endmodule

// File: tb/tb_fast_mask_builder.sv
// Randomised and directed checks of fast_mask_builder against an integer reference model.
module tb_fast_mask_builder;

    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic [PW-1:0] thresh;
    logic          in_valid;
    logic          in_ready;
    logic          in_sop;
    logic [PW-1:0] in_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   mask_d;
    logic [15:0]   mask_b;
    logic          sync_err;
`ifdef FAST_SCORE_EN
    logic [PW+3:0] score;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fast_mask_builder #(.PIXEL_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .thresh    (thresh),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mask_d    (mask_d),
        .mask_b    (mask_b),
        .sync_err  (sync_err)
`ifdef FAST_SCORE_EN
        ,
        .score     (score)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Masks and score from the first n circle pixels, straight from the thresholding rules.
    function automatic void ref_model(input int c, input int t, input int pix[16], input int n,
                                      output logic [15:0] md, output logic [15:0] mb, output int sc);
        int sb;
        int sd;
        sb = 0;
        sd = 0;
        md = '0;
        mb = '0;
        for (int i = 0; i < n; i++) begin
            if (c - t >= 0 && pix[i] < c - t) begin
                md[15-i] = 1'b1;
                sd += c - t - pix[i];
            end else if (pix[i] > c + t) begin
                mb[15-i] = 1'b1;
                sb += pix[i] - c - t;
            end
        end
        sc = (sb > sd) ? sb : sd;
    endfunction

    // Present one beat from posedge+1 and return at posedge+1 after it is accepted.
    task automatic send_beat(input logic sop, input int pix, input int th);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_sop   = sop;
        in_pixel = PW'(pix);
        thresh   = PW'(th);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("beat_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_pixel = '0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_packet(input string tag, input int c, input int t, input int pix[16],
                              input int max_gap, input int hold_n);
        logic [15:0] emd;
        logic [15:0] emb;
        int esc;
        ref_model(c, t, pix, 16, emd, emb, esc);
        send_beat(1'b1, c, t);
        for (int i = 0; i < 16; i++) begin
            if (max_gap > 0) idle_cycles($urandom_range(max_gap, 0));
            send_beat(1'b0, pix[i], $urandom_range(255, 0));
        end
        chk({tag, "_latency"}, 32'(out_valid), 32'd1);
        chk({tag, "_mask_d"}, 32'(mask_d), 32'(emd));
        chk({tag, "_mask_b"}, 32'(mask_b), 32'(emb));
        chk({tag, "_disjoint"}, 32'(mask_d & mask_b), 32'd0);
        chk({tag, "_no_sync_err"}, 32'(sync_err), 32'd0);
`ifdef FAST_SCORE_EN
        chk({tag, "_score"}, 32'(score), 32'(esc));
`endif
        out_ready = 1'b0;
        for (int k = 0; k < hold_n; k++) begin
            @(negedge clk);
            chk({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
            chk({tag, "_hold_md"}, 32'(mask_d), 32'(emd));
            chk({tag, "_hold_mb"}, 32'(mask_b), 32'(emb));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_released"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_again"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int pix[16];
        int c;
        int t;
        logic [15:0] emd;
        logic [15:0] emb;
        int esc;

        rst = 1'b1; ce = 1'b1; thresh = '0; in_valid = 1'b0; in_sop = 1'b0;
        in_pixel = '0; out_ready = 1'b0;
        idle_cycles(3);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mask_d", 32'(mask_d), 32'd0);
        chk("rst_mask_b", 32'(mask_b), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef FAST_SCORE_EN
        chk("rst_score", 32'(score), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // 1: everything darker
        for (int i = 0; i < 16; i++) pix[i] = 50;
        run_packet("t1", 100, 20, pix, 0, 0);

        // 2: first nine brighter, boundary values at pixels 9 and 10 stay clear
        for (int i = 0; i < 16; i++) pix[i] = (i <= 8) ? 130 : 100;
        run_packet("t2", 100, 20, pix, 0, 1);
        chk("t2_const_b", 32'(mask_b), 32'h0000_FF80);
        pix[9] = 120; pix[10] = 80;
        run_packet("t2b", 100, 20, pix, 0, 0);
        chk("t2b_const_b", 32'(mask_b), 32'h0000_FF80);
        chk("t2b_const_d", 32'(mask_d), 32'h0000_0000);

        // 3: no underflow below zero, no overflow above full scale
        for (int i = 0; i < 16; i++) pix[i] = 0;
        run_packet("t3a", 10, 20, pix, 0, 0);
        chk("t3a_const_d", 32'(mask_d), 32'd0);
        for (int i = 0; i < 16; i++) pix[i] = 255;
        run_packet("t3b", 250, 20, pix, 0, 0);
        chk("t3b_const_b", 32'(mask_b), 32'd0);

        // 4: long backpressure, then back-to-back packet
        for (int i = 0; i < 16; i++) pix[i] = (i % 3 == 0) ? 10 : 200;
        run_packet("t4", 100, 20, pix, 0, 5);
        run_packet("t4n", 90, 5, pix, 0, 0);

        // 5: resync after seven circle beats, then a stray beat in IDLE
        send_beat(1'b1, 200, 10);
        for (int i = 0; i < 7; i++) send_beat(1'b0, 0, 0);
        for (int i = 0; i < 16; i++) pix[i] = (i < 4) ? 255 : 30;
        run_packet("t5", 60, 15, pix, 0, 0);
        send_beat(1'b0, 77, 3);
        chk("t5_sync_err_pulse", 32'(sync_err), 32'd1);
        chk("t5_drop_no_valid", 32'(out_valid), 32'd0);
        idle_cycles(1);
        chk("t5_sync_err_clear", 32'(sync_err), 32'd0);
        run_packet("t5b", 60, 15, pix, 0, 0);

        // 6: ce stall mid-collect, then reset at beat 10
        for (int i = 0; i < 16; i++) pix[i] = 220;
        send_beat(1'b1, 100, 20);
        for (int i = 0; i < 5; i++) send_beat(1'b0, pix[i], 0);
        ce = 1'b0; in_valid = 1'b1; in_sop = 1'b0; in_pixel = '0;
        ref_model(100, 20, pix, 5, emd, emb, esc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_ce_rdy", 32'(in_ready), 32'd0);
            chk("t6_ce_mb", 32'(mask_b), 32'(emb));
            chk("t6_ce_md", 32'(mask_d), 32'(emd));
            @(posedge clk);
            #1;
        end
        ce = 1'b1; in_valid = 1'b0;
        for (int i = 5; i < 10; i++) send_beat(1'b0, pix[i], 0);
        ref_model(100, 20, pix, 10, emd, emb, esc);
        chk("t6_partial_mb", 32'(mask_b), 32'(emb));
        chk("t6_partial_md", 32'(mask_d), 32'(emd));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_rst_vld", 32'(out_valid), 32'd0);
        chk("t6_rst_md", 32'(mask_d), 32'd0);
        chk("t6_rst_mb", 32'(mask_b), 32'd0);
        idle_cycles(20);
        chk("t6_no_output", 32'(out_valid), 32'd0);
        chk("t6_idle_ready", 32'(in_ready), 32'd1);

        // random packets with input gaps and output stalls
        for (int n = 0; n < 25; n++) begin
            c = $urandom_range(255, 0);
            t = $urandom_range(60, 0);
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(3, 0))
                    0: pix[i] = $urandom_range(255, 0);
                    1: pix[i] = (c + t <= 255) ? c + t : 255;
                    2: pix[i] = (c - t >= 0) ? c - t : 0;
                    default: pix[i] = $urandom_range((c + 30 > 255) ? 255 : c + 30,
                                                     (c - 30 < 0) ? 0 : c - 30);
                endcase
            end
            run_packet("rnd", c, t, pix, 2, $urandom_range(3, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
